// File: rtl/match_controller_pkg.sv
// Shared types and constants for the match controller: FSM state encoding,
// winner codes, default frame counts and timer widths.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_COUNTDOWN  = 3'd1,
        ST_FIGHT      = 3'd2,
        ST_KO         = 3'd3,
        ST_MATCH_OVER = 3'd4
    } state_e;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;
    localparam logic [1:0] WIN_DRAW = 2'd3;

    localparam int DEF_LIVES            = 3;
    localparam int DEF_STUN_FRAMES      = 30;
    localparam int DEF_COUNTDOWN_FRAMES = 180;
    localparam int DEF_KO_FRAMES        = 120;
    localparam int DEF_ROUNDS_TO_WIN    = 2;
    localparam int DEF_ROUND_FRAMES     = 5400;

    // Phase and stun timers share one width; the round timer is wider.
    localparam int TIMER_W = 8;
    localparam int ROUND_W = 13;

    // Lives never go below zero.
    function automatic logic [1:0] sat_dec2(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction

endpackage

// File: rtl/match_controller_if.sv
// Status/handshake bundle between the match controller and the player FSMs,
// hit detector and status display. time_left exists only with ROUND_TIMEOUT_EN.
interface match_controller_if;
    import game_pkg::*;

    logic       frame_tick;
    logic       start;
    logic       hit1_flag;
    logic       hit2_flag;
    logic       fight_en;
    logic       hd_clear;
    logic       stun1;
    logic       stun2;
    logic [1:0] lives1;
    logic [1:0] lives2;
    logic [1:0] wins1;
    logic [1:0] wins2;
    logic [1:0] round_num;
    logic [1:0] winner;
    logic [2:0] state_o;
`ifdef ROUND_TIMEOUT_EN
    logic [ROUND_W-1:0] time_left;
`endif

    modport master (
        output frame_tick, start, hit1_flag, hit2_flag,
        input  fight_en, hd_clear, stun1, stun2, lives1, lives2,
        input  wins1, wins2, round_num, winner, state_o
`ifdef ROUND_TIMEOUT_EN
        , input time_left
`endif
    );

    modport slave (
        input  frame_tick, start, hit1_flag, hit2_flag,
        output fight_en, hd_clear, stun1, stun2, lives1, lives2,
        output wins1, wins2, round_num, winner, state_o
`ifdef ROUND_TIMEOUT_EN
        , output time_left
`endif
    );

endinterface

// File: rtl/match_controller_frame_timer.sv
// Loadable, non-wrapping down-counter stepped by frame_tick. A load in the
// same cycle as a tick takes priority.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         frame_tick,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    // Next count: load wins, otherwise decrement on tick and hold at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (frame_tick && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/match_controller.sv
// Round/match sequencer: owns lives, stun timing, round wins and match end,
// gates the players through fight_en and clears the hit detector between
// rounds. Optional round clock enabled by the ROUND_TIMEOUT_EN macro.
module match_controller
    import game_pkg::*;
#(
    parameter int LIVES            = DEF_LIVES,
    parameter int STUN_FRAMES      = DEF_STUN_FRAMES,
    parameter int COUNTDOWN_FRAMES = DEF_COUNTDOWN_FRAMES,
    parameter int KO_FRAMES        = DEF_KO_FRAMES,
    parameter int ROUNDS_TO_WIN    = DEF_ROUNDS_TO_WIN
`ifdef ROUND_TIMEOUT_EN
    , parameter int ROUND_FRAMES   = DEF_ROUND_FRAMES
`endif
) (
    input logic               clk,
    input logic               reset,
    match_controller_if.slave bus
);

    localparam logic [1:0]         LIVES_V  = 2'(LIVES);
    localparam logic [1:0]         TARGET_V = 2'(ROUNDS_TO_WIN);
    localparam logic [TIMER_W-1:0] CD_V     = TIMER_W'(COUNTDOWN_FRAMES);
    localparam logic [TIMER_W-1:0] KO_V     = TIMER_W'(KO_FRAMES);
    localparam logic [TIMER_W-1:0] STUN_V   = TIMER_W'(STUN_FRAMES);

    state_e     state_q, state_d;
    logic [1:0] lives1_q, lives1_d, lives2_q, lives2_d;
    logic [1:0] wins1_q, wins1_d, wins2_q, wins2_d;
    logic [1:0] round_q, round_d, winner_q, winner_d;
    logic       fight_en_q, fight_en_d, hd_clear_q, hd_clear_d;
    logic       hit1_q, hit2_q, start_q;

    logic               phase_load, stun1_load, stun2_load;
    logic [TIMER_W-1:0] phase_val, stun1_val, stun2_val;
    logic               phase_zero, stun1_zero, stun2_zero;
    logic [TIMER_W-1:0] phase_cnt_unused, stun1_cnt_unused, stun2_cnt_unused;

    logic ev1, ev2, start_rise, restart, time_zero;

    assign ev1        = bus.hit1_flag & ~hit1_q & (state_q == ST_FIGHT);
    assign ev2        = bus.hit2_flag & ~hit2_q & (state_q == ST_FIGHT);
    assign start_rise = bus.start & ~start_q;
    assign restart    = (state_q == ST_MATCH_OVER) & start_rise;

`ifdef ROUND_TIMEOUT_EN
    logic               round_load;
    logic [ROUND_W-1:0] round_val;

    // Round clock starts on FIGHT entry, runs only in FIGHT, cleared on rematch.
    assign round_load = restart | ((state_d == ST_FIGHT) & (state_q != ST_FIGHT));
    assign round_val  = restart ? '0 : ROUND_W'(ROUND_FRAMES);

    frame_timer #(.W(ROUND_W)) u_round_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (round_load),
        .load_val   (round_val),
        .frame_tick (bus.frame_tick & (state_q == ST_FIGHT)),
        .count      (bus.time_left),
        .zero       (time_zero)
    );
`else
    assign time_zero = 1'b0;
`endif

    // Next-state, score bookkeeping and timer load requests.
    always_comb begin
        state_d    = state_q;
        lives1_d   = lives1_q;
        lives2_d   = lives2_q;
        wins1_d    = wins1_q;
        wins2_d    = wins2_q;
        round_d    = round_q;
        winner_d   = winner_q;
        hd_clear_d = 1'b0;
        phase_load = 1'b0;
        phase_val  = '0;
        stun1_load = 1'b0;
        stun1_val  = '0;
        stun2_load = 1'b0;
        stun2_val  = '0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d    = ST_COUNTDOWN;
                    phase_load = 1'b1;
                    phase_val  = CD_V;
                    hd_clear_d = 1'b1;
                end
            end
            ST_COUNTDOWN: begin
                if (phase_zero) state_d = ST_FIGHT;
            end
            ST_FIGHT: begin
                if (ev1) begin
                    lives2_d   = sat_dec2(lives2_q);
                    stun2_load = 1'b1;
                    stun2_val  = STUN_V;
                end
                if (ev2) begin
                    lives1_d   = sat_dec2(lives1_q);
                    stun1_load = 1'b1;
                    stun1_val  = STUN_V;
                end
                // KO by lives outranks the round clock; double KO awards nothing.
                if ((lives1_d == 2'd0) || (lives2_d == 2'd0)) begin
                    state_d = ST_KO;
                    if ((lives2_d == 2'd0) && (lives1_d != 2'd0)) wins1_d = wins1_q + 2'd1;
                    else if ((lives1_d == 2'd0) && (lives2_d != 2'd0)) wins2_d = wins2_q + 2'd1;
                end else if (time_zero) begin
                    state_d = ST_KO;
                    if (lives1_d > lives2_d) wins1_d = wins1_q + 2'd1;
                    else if (lives2_d > lives1_d) wins2_d = wins2_q + 2'd1;
                end
                if (state_d == ST_KO) begin
                    phase_load = 1'b1;
                    phase_val  = KO_V;
                    stun1_load = 1'b1;
                    stun1_val  = '0;
                    stun2_load = 1'b1;
                    stun2_val  = '0;
                end
            end
            ST_KO: begin
                if (phase_zero) begin
                    if ((wins1_q == TARGET_V) || (wins2_q == TARGET_V)) begin
                        state_d  = ST_MATCH_OVER;
                        winner_d = (wins1_q == TARGET_V) ? WIN_P1 : WIN_P2;
                    end else if ((round_q == 2'd3) && (wins1_q == wins2_q)) begin
                        state_d  = ST_MATCH_OVER;
                        winner_d = WIN_DRAW;
                    end else begin
                        state_d    = ST_COUNTDOWN;
                        round_d    = (round_q == 2'd3) ? 2'd3 : round_q + 2'd1;
                        lives1_d   = LIVES_V;
                        lives2_d   = LIVES_V;
                        hd_clear_d = 1'b1;
                        phase_load = 1'b1;
                        phase_val  = CD_V;
                    end
                end
            end
            ST_MATCH_OVER: begin
                if (restart) begin
                    state_d    = ST_COUNTDOWN;
                    lives1_d   = LIVES_V;
                    lives2_d   = LIVES_V;
                    wins1_d    = 2'd0;
                    wins2_d    = 2'd0;
                    round_d    = 2'd1;
                    winner_d   = WIN_NONE;
                    hd_clear_d = 1'b1;
                    phase_load = 1'b1;
                    phase_val  = CD_V;
                    stun1_load = 1'b1;
                    stun2_load = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        fight_en_d = (state_d == ST_FIGHT);
    end

    // State, score and registered-output flops; edge detectors track inputs always.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            lives1_q   <= LIVES_V;
            lives2_q   <= LIVES_V;
            wins1_q    <= 2'd0;
            wins2_q    <= 2'd0;
            round_q    <= 2'd1;
            winner_q   <= WIN_NONE;
            fight_en_q <= 1'b0;
            hd_clear_q <= 1'b0;
            hit1_q     <= 1'b0;
            hit2_q     <= 1'b0;
            start_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            lives1_q   <= lives1_d;
            lives2_q   <= lives2_d;
            wins1_q    <= wins1_d;
            wins2_q    <= wins2_d;
            round_q    <= round_d;
            winner_q   <= winner_d;
            fight_en_q <= fight_en_d;
            hd_clear_q <= hd_clear_d;
            hit1_q     <= bus.hit1_flag;
            hit2_q     <= bus.hit2_flag;
            start_q    <= bus.start;
        end
    end

    frame_timer #(.W(TIMER_W)) u_phase_timer (
        .clk(clk), .reset(reset), .load(phase_load), .load_val(phase_val),
        .frame_tick(bus.frame_tick), .count(phase_cnt_unused), .zero(phase_zero)
    );

    frame_timer #(.W(TIMER_W)) u_stun1_timer (
        .clk(clk), .reset(reset), .load(stun1_load), .load_val(stun1_val),
        .frame_tick(bus.frame_tick), .count(stun1_cnt_unused), .zero(stun1_zero)
    );

    frame_timer #(.W(TIMER_W)) u_stun2_timer (
        .clk(clk), .reset(reset), .load(stun2_load), .load_val(stun2_val),
        .frame_tick(bus.frame_tick), .count(stun2_cnt_unused), .zero(stun2_zero)
    );

    assign bus.fight_en  = fight_en_q;
    assign bus.hd_clear  = hd_clear_q;
    assign bus.stun1     = ~stun1_zero;
    assign bus.stun2     = ~stun2_zero;
    assign bus.lives1    = lives1_q;
    assign bus.lives2    = lives2_q;
    assign bus.wins1     = wins1_q;
    assign bus.wins2     = wins2_q;
    assign bus.round_num = round_q;
    assign bus.winner    = winner_q;
    assign bus.state_o   = state_q;

endmodule

// File: tb/tb_match_controller.sv
// Directed, table-driven bench for match_controller. Each row applies inputs
// for a number of clocks (or an asynchronous reset pulse) and then compares
// the packed status outputs against hand-computed values.
module tb_match_controller;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    match_controller_if bus ();

    match_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

`ifdef ROUND_TIMEOUT_EN
    match_controller_if bus_to ();

    match_controller #(.ROUND_FRAMES(10)) dut_to (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_to.slave)
    );
`endif

    typedef struct {
        bit         rst;
        bit         start;
        bit         tick;
        bit         h1;
        bit         h2;
        int         reps;
        logic [18:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   tests = 0;
    int   fails = 0;

    // Expected bundle: {state, fight_en, hd_clear, stun1, stun2, lives1, lives2, wins1, wins2, round, winner}
    function automatic vec_t v(bit rs, bit st_i, bit tk, bit h1, bit h2, int reps,
                               logic [2:0] st, bit fe, bit hc, bit s1, bit s2,
                               logic [1:0] l1, logic [1:0] l2, logic [1:0] w1,
                               logic [1:0] w2, logic [1:0] rn, logic [1:0] wn);
        vec_t r;
        r.rst = rs; r.start = st_i; r.tick = tk; r.h1 = h1; r.h2 = h2; r.reps = reps;
        r.exp = {st, fe, hc, s1, s2, l1, l2, w1, w2, rn, wn};
        return r;
    endfunction

    function automatic logic [18:0] obs();
        return {bus.state_o, bus.fight_en, bus.hd_clear, bus.stun1, bus.stun2,
                bus.lives1, bus.lives2, bus.wins1, bus.wins2, bus.round_num, bus.winner};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

`ifdef ROUND_TIMEOUT_EN
    task automatic to_cyc(input bit st_i, input bit tk, input bit h1, input bit h2, input int n);
        bus_to.start = st_i; bus_to.frame_tick = tk;
        bus_to.hit1_flag = h1; bus_to.hit2_flag = h2;
        step(n);
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.start = 0; bus.frame_tick = 0; bus.hit1_flag = 0; bus.hit2_flag = 0;
`ifdef ROUND_TIMEOUT_EN
        bus_to.start = 0; bus_to.frame_tick = 0; bus_to.hit1_flag = 0; bus_to.hit2_flag = 0;
`endif

        // Round 1: start (tick coincident with load), countdown, held hit, stun, KO by P1
        tbl.push_back(v(0,1,1,0,0,1,   3'd1,0,1,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,1,0,0,179, 3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,1,0,0,1,   3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,1,0,0,0,2,   3'd2,1,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,0,1,0,10,  3'd2,1,0,0,1, 3,2,0,0,1,0));
        tbl.push_back(v(0,0,1,0,0,29,  3'd2,1,0,0,1, 3,2,0,0,1,0));
        tbl.push_back(v(0,0,1,0,0,1,   3'd2,1,0,0,0, 3,2,0,0,1,0));
        tbl.push_back(v(0,0,0,0,1,1,   3'd2,1,0,1,0, 2,2,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,1,0, 2,2,0,0,1,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd2,1,0,1,1, 2,1,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,1,1, 2,1,0,0,1,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd3,0,0,0,0, 2,0,1,0,1,0));
        tbl.push_back(v(0,0,1,0,1,119, 3'd3,0,0,0,0, 2,0,1,0,1,0));
        tbl.push_back(v(0,0,1,0,0,1,   3'd3,0,0,0,0, 2,0,1,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd1,0,1,0,0, 3,3,1,0,2,0));
        // Round 2: lives to 1/1, simultaneous hits -> double KO, no win
        tbl.push_back(v(0,0,0,0,0,1,   3'd1,0,0,0,0, 3,3,1,0,2,0));
        tbl.push_back(v(0,0,1,0,0,180, 3'd1,0,0,0,0, 3,3,1,0,2,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,0, 3,3,1,0,2,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd2,1,0,0,1, 3,2,1,0,2,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,1, 3,2,1,0,2,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd2,1,0,0,1, 3,1,1,0,2,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,1, 3,1,1,0,2,0));
        tbl.push_back(v(0,0,0,0,1,1,   3'd2,1,0,1,1, 2,1,1,0,2,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,1,1, 2,1,1,0,2,0));
        tbl.push_back(v(0,0,0,0,1,1,   3'd2,1,0,1,1, 1,1,1,0,2,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,1,1, 1,1,1,0,2,0));
        tbl.push_back(v(0,0,1,1,1,1,   3'd3,0,0,0,0, 0,0,1,0,2,0));
        tbl.push_back(v(0,0,1,0,0,120, 3'd3,0,0,0,0, 0,0,1,0,2,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd1,0,1,0,0, 3,3,1,0,3,0));
        // Round 3: P1 wins the match; held start must not restart
        tbl.push_back(v(0,0,0,0,0,1,   3'd1,0,0,0,0, 3,3,1,0,3,0));
        tbl.push_back(v(0,0,1,0,0,180, 3'd1,0,0,0,0, 3,3,1,0,3,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,0, 3,3,1,0,3,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd2,1,0,0,1, 3,2,1,0,3,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,1, 3,2,1,0,3,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd2,1,0,0,1, 3,1,1,0,3,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,1, 3,1,1,0,3,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd3,0,0,0,0, 3,0,2,0,3,0));
        tbl.push_back(v(0,0,1,0,0,120, 3'd3,0,0,0,0, 3,0,2,0,3,0));
        tbl.push_back(v(0,1,0,0,0,1,   3'd4,0,0,0,0, 3,0,2,0,3,1));
        tbl.push_back(v(0,1,0,0,0,3,   3'd4,0,0,0,0, 3,0,2,0,3,1));
        tbl.push_back(v(0,0,1,0,0,2,   3'd4,0,0,0,0, 3,0,2,0,3,1));
        tbl.push_back(v(0,1,0,0,0,1,   3'd1,0,1,0,0, 3,3,0,0,1,0));
        // Rematch, then asynchronous reset mid-fight with lives 1/2 and stuns active
        tbl.push_back(v(0,0,0,0,0,1,   3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,1,0,0,180, 3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,0,1,0,1,   3'd2,1,0,0,1, 3,2,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,1, 3,2,0,0,1,0));
        tbl.push_back(v(0,0,0,0,1,1,   3'd2,1,0,1,1, 2,2,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,1,1, 2,2,0,0,1,0));
        tbl.push_back(v(0,0,0,0,1,1,   3'd2,1,0,1,1, 1,2,0,0,1,0));
        tbl.push_back(v(1,0,0,0,0,0,   3'd0,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,1,0,0,0,1,   3'd1,0,1,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,1,0,0,179, 3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,1,0,0,1,   3'd1,0,0,0,0, 3,3,0,0,1,0));
        tbl.push_back(v(0,0,0,0,0,1,   3'd2,1,0,0,0, 3,3,0,0,1,0));

        // Reset state while reset is held
        step(3);
        check("reset_state", 32'(obs()), 32'({3'd0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd3,2'd0,2'd0,2'd1,2'd0}));
        reset = 1'b0;
        step(1);
        check("idle_after_reset", 32'(obs()), 32'({3'd0,1'b0,1'b0,1'b0,1'b0,2'd3,2'd3,2'd0,2'd0,2'd1,2'd0}));

        for (int r = 0; r < tbl.size(); r++) begin
            bus.start     = tbl[r].start;
            bus.frame_tick = tbl[r].tick;
            bus.hit1_flag = tbl[r].h1;
            bus.hit2_flag = tbl[r].h2;
            if (tbl[r].rst) begin
                #1 reset = 1'b1;
                #1;
                check($sformatf("row%0d_async_reset", r), 32'(obs()), 32'(tbl[r].exp));
                reset = 1'b0;
                #1;
            end else begin
                step(tbl[r].reps);
                check($sformatf("row%0d", r), 32'(obs()), 32'(tbl[r].exp));
            end
        end

`ifdef ROUND_TIMEOUT_EN
        // Round clock of 10 frames: lives 3/2 at expiry gives P1 the round,
        // equal lives at expiry awards nothing.
        to_cyc(1, 0, 0, 0, 1);
        to_cyc(0, 1, 0, 0, 180);
        to_cyc(0, 0, 0, 0, 1);
        check("to_fight_entry", 32'({bus_to.state_o, bus_to.time_left}), 32'({3'd2, 13'd10}));
        to_cyc(0, 0, 1, 0, 1);
        to_cyc(0, 1, 0, 0, 10);
        check("to_expired", 32'({bus_to.state_o, bus_to.time_left, bus_to.lives2}), 32'({3'd2, 13'd0, 2'd2}));
        to_cyc(0, 0, 0, 0, 1);
        check("to_ko_more_lives", 32'({bus_to.state_o, bus_to.wins1, bus_to.wins2}), 32'({3'd3, 2'd1, 2'd0}));
        to_cyc(0, 1, 0, 0, 120);
        to_cyc(0, 0, 0, 0, 1);
        to_cyc(0, 1, 0, 0, 180);
        to_cyc(0, 0, 0, 0, 1);
        to_cyc(0, 1, 0, 0, 10);
        to_cyc(0, 0, 0, 0, 1);
        check("to_ko_equal_lives", 32'({bus_to.state_o, bus_to.wins1, bus_to.wins2, bus_to.round_num}),
              32'({3'd3, 2'd1, 2'd0, 2'd2}));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
